// File: rtl/payment_pkg.sv
// Package: payment_pkg
// Shared types and helpers for the vending money/credit controller.
//   state_t      controller FSM states
//   COIN_VAL_DEF default packed coin values, ascending from channel 0
//                (5, 10, 25, 100)
//   coin_value() extracts one coin value from a packed coin-value vector
package payment_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VEND,
        VEND_REL,
        CHANGE,
        CANCEL_HS
    } state_t;

    localparam int NUM_COIN_DEF = 4;
    localparam int PRICE_W_DEF  = 8;
    localparam logic [NUM_COIN_DEF*PRICE_W_DEF-1:0] COIN_VAL_DEF =
        {8'd100, 8'd25, 8'd10, 8'd5};

    // Widest packed coin-value vector coin_value() can take.
    localparam int COIN_PACK_MAX = 256;

    // Value of coin channel idx in a packed vector of priceW-bit entries.
    function automatic logic [31:0] coin_value(input logic [COIN_PACK_MAX-1:0] vals,
                                               input int priceW,
                                               input int idx);
        logic [COIN_PACK_MAX-1:0] shifted;
        logic [COIN_PACK_MAX-1:0] mask;
        shifted = vals >> (idx * priceW);
        mask    = (COIN_PACK_MAX'(1) << priceW) - COIN_PACK_MAX'(1);
        return 32'(shifted & mask);
    endfunction

endpackage

// File: rtl/change_picker.sv
// Module: change_picker
// Combinational greedy selector: picks the largest coin whose value does
// not exceed the current balance.
//   balance     in   BAL_W     amount still owed to the customer
//   coinOneHot  out  NUM_COIN  one-hot channel of the chosen coin
//   coinAmt     out  BAL_W     value of the chosen coin
//   fits        out  1         a coin fits (0 when balance is below every coin)
module change_picker
    import payment_pkg::*;
#(
    parameter int NUM_COIN = 4,
    parameter int PRICE_W  = 8,
    parameter int BAL_W    = 10,
    parameter logic [NUM_COIN*PRICE_W-1:0] COIN_VAL = COIN_VAL_DEF
) (
    input  logic [BAL_W-1:0]    balance,
    output logic [NUM_COIN-1:0] coinOneHot,
    output logic [BAL_W-1:0]    coinAmt,
    output logic                fits
);

    logic [BAL_W-1:0] coinVals [NUM_COIN];

    for (genvar i = 0; i < NUM_COIN; i++) begin : g_coin_val
        assign coinVals[i] = BAL_W'(coin_value(COIN_PACK_MAX'(COIN_VAL), PRICE_W, i));
    end

    // Channels are ascending in value, so the last fitting channel in an
    // upward scan is the largest coin that fits.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        coinOneHot = '0;
        coinAmt    = '0;
        fits       = 1'b0;
        for (int i = 0; i < NUM_COIN; i++) begin
            if (coinVals[i] != '0 && coinVals[i] <= balance) begin
                coinOneHot = NUM_COIN'(1) << i;
                coinAmt    = coinVals[i];
                fits       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/payment_ctrl.sv
// Module: payment_ctrl
// Money/credit controller for the vending datapath. Accumulates coins, or
// debits a credit balance, against the selected item price, runs a 4-phase
// vend handshake with inventory and pays out change coin-by-coin.
//   clk, rst      clock, synchronous active-high reset
//   price_tbl     packed price table, captured while rst=1
//   credit_init   starting credit, captured while rst=1
//   coin_in       coin sensor levels, one bit per channel
//   pay_credit    0 = pay cash, 1 = pay from credit (sampled in IDLE)
//   sel_idx       selected item; sel_valid qualifies a purchase
//   cancel_req    4-phase cancel request; cancel_ack its acknowledge
//   vend_req      4-phase dispense request; vend_ack its acknowledge
//   chg_ready     dispenser accepts a coin; chg_valid/chg_coin present it
//   coin_reject   1-cycle pulse for a coin that was not (fully) accepted
//   balance       cash balance; credit_bal credit balance
module payment_ctrl
    import payment_pkg::*;
#(
    parameter int NUM_ITEMS = 8,
    parameter int PRICE_W   = 8,
    parameter int BAL_W     = 10,
    parameter int NUM_COIN  = 4,
    parameter logic [NUM_COIN*PRICE_W-1:0] COIN_VAL = COIN_VAL_DEF,
    localparam int SEL_W    = $clog2(NUM_ITEMS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_ITEMS*PRICE_W-1:0] price_tbl,
    input  logic [BAL_W-1:0]             credit_init,
    input  logic [NUM_COIN-1:0]          coin_in,
    input  logic                         pay_credit,
    input  logic [SEL_W-1:0]             sel_idx,
    input  logic                         sel_valid,
    input  logic                         cancel_req,
    input  logic                         vend_ack,
    input  logic                         chg_ready,
    output logic                         vend_req,
    output logic                         cancel_ack,
    output logic [NUM_COIN-1:0]          chg_coin,
    output logic                         chg_valid,
    output logic                         coin_reject,
    output logic [BAL_W-1:0]             balance,
    output logic [BAL_W-1:0]             credit_bal
);

    localparam int SUM_W = BAL_W + $clog2(NUM_COIN) + 1;
    localparam logic [BAL_W-1:0] BAL_MAX = '1;

    state_t             state;
    state_t             stateNext;
    logic [PRICE_W-1:0] priceTable [NUM_ITEMS];
    logic [BAL_W-1:0]   coinVals [NUM_COIN];
    logic [NUM_COIN-1:0] coinSync;
    logic [NUM_COIN-1:0] coinPrev;
    logic [NUM_COIN-1:0] coinEdge;
    logic [SUM_W-1:0]   coinSum;
    logic [SUM_W-1:0]   coinAdded;
    logic               selInRange;
    logic [BAL_W-1:0]   priceSel;
    logic               cancelPath;     // current CHANGE visit was started by cancel
    logic               payCredit;      // mode latched for the purchase in flight
    logic [NUM_COIN-1:0] pickCoin;
    logic [BAL_W-1:0]   pickAmt;
    logic               pickFits;

    logic [BAL_W-1:0]   balanceNext;
    logic [BAL_W-1:0]   creditNext;
    logic               vendReqNext;
    logic               cancelAckNext;
    logic               cancelPathNext;
    logic               payCreditNext;
    logic               coinRejectNext;

    for (genvar i = 0; i < NUM_COIN; i++) begin : g_coin_val
        assign coinVals[i] = BAL_W'(coin_value(COIN_PACK_MAX'(COIN_VAL), PRICE_W, i));
    end

    change_picker #(
        .NUM_COIN (NUM_COIN),
        .PRICE_W  (PRICE_W),
        .BAL_W    (BAL_W),
        .COIN_VAL (COIN_VAL)
    ) uPicker (
        .balance    (balance),
        .coinOneHot (pickCoin),
        .coinAmt    (pickAmt),
        .fits       (pickFits)
    );

    // Each rising sensor edge is one coin; simultaneous edges all count.
    assign coinEdge = coinSync & ~coinPrev;

    always_comb begin
        coinSum = '0;
        for (int i = 0; i < NUM_COIN; i++) begin
            if (coinEdge[i]) begin
                coinSum = coinSum + SUM_W'(coinVals[i]);
            end
        end
    end

    assign coinAdded  = SUM_W'(balance) + coinSum;
    assign selInRange = 32'(sel_idx) < NUM_ITEMS;
    assign priceSel   = selInRange ? BAL_W'(priceTable[sel_idx]) : '0;

    always_comb begin
        stateNext      = state;
        balanceNext    = balance;
        creditNext     = credit_bal;
        vendReqNext    = vend_req;
        cancelAckNext  = cancel_ack;
        cancelPathNext = cancelPath;
        payCreditNext  = payCredit;
        coinRejectNext = 1'b0;
        chg_valid      = 1'b0;
        chg_coin       = '0;

        // Coins are only taken in IDLE. An overflowing batch clamps the
        // balance at full scale and flags the excess as rejected.
        if (coinEdge != '0) begin
            if (state != IDLE) begin
                coinRejectNext = 1'b1;
            end else if (coinAdded > SUM_W'(BAL_MAX)) begin
                balanceNext    = BAL_MAX;
                coinRejectNext = 1'b1;
            end else begin
                balanceNext = BAL_W'(coinAdded);
            end
        end

        case (state)
            IDLE: begin
                if (cancel_req) begin
                    cancelPathNext = 1'b1;
                    stateNext      = CHANGE;
                end else if (sel_valid && selInRange) begin
                    // The check sees last cycle's balance; any coin landing
                    // this cycle only raises it, so the debit cannot underflow.
                    if (pay_credit && credit_bal >= priceSel) begin
                        creditNext    = credit_bal - priceSel;
                        payCreditNext = 1'b1;
                        vendReqNext   = 1'b1;
                        stateNext     = VEND;
                    end else if (!pay_credit && balance >= priceSel) begin
                        balanceNext   = balanceNext - priceSel;
                        payCreditNext = 1'b0;
                        vendReqNext   = 1'b1;
                        stateNext     = VEND;
                    end
                end
            end
            VEND: begin
                if (vend_ack) begin
                    vendReqNext = 1'b0;
                    stateNext   = VEND_REL;
                end
            end
            VEND_REL: begin
                if (!vend_ack) begin
                    if (!payCredit && balance != '0) begin
                        cancelPathNext = 1'b0;
                        stateNext      = CHANGE;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            CHANGE: begin
                // A residual smaller than every coin stays in the balance.
                if (balance == '0 || !pickFits) begin
                    stateNext     = cancelPath ? CANCEL_HS : IDLE;
                    cancelAckNext = cancelPath;
                end else if (chg_ready && !rst) begin
                    chg_valid   = 1'b1;
                    chg_coin    = pickCoin;
                    balanceNext = balance - pickAmt;
                end
            end
            CANCEL_HS: begin
                if (!cancel_req) begin
                    cancelAckNext  = 1'b0;
                    cancelPathNext = 1'b0;
                    stateNext      = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated only with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state       <= IDLE;
            balance     <= '0;
            credit_bal  <= credit_init;
            vend_req    <= 1'b0;
            cancel_ack  <= 1'b0;
            coin_reject <= 1'b0;
            cancelPath  <= 1'b0;
            payCredit   <= 1'b0;
            coinSync    <= '0;
            coinPrev    <= '0;
            // NOTE: the price table is loaded under reset on purpose: reset
            // is its only capture window, the contents are held otherwise.
            for (int i = 0; i < NUM_ITEMS; i++) begin
                priceTable[i] <= price_tbl[i*PRICE_W +: PRICE_W];
            end
        end else begin
            state       <= stateNext;
            balance     <= balanceNext;
            credit_bal  <= creditNext;
            vend_req    <= vendReqNext;
            cancel_ack  <= cancelAckNext;
            coin_reject <= coinRejectNext;
            cancelPath  <= cancelPathNext;
            payCredit   <= payCreditNext;
            coinSync    <= coin_in;
            coinPrev    <= coinSync;
        end
    end

endmodule

// File: tb/tb_payment_ctrl.sv
// Testbench: tb_payment_ctrl
// Directed purchases, cancels and corner cases for payment_ctrl. Stimulus
// pushes expected DUT events (vend start, change coin, coin reject, cancel
// acknowledge) into a scoreboard queue; a negedge monitor pops and compares
// each event as the DUT produces it. Levels are checked with check().
module tb_payment_ctrl;

    typedef enum logic [1:0] {EV_VEND, EV_CHG, EV_REJ, EV_CACK} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] data;
    } ev_t;

    localparam logic [3:0] NICKEL  = 4'b0001;
    localparam logic [3:0] DIME    = 4'b0010;
    localparam logic [3:0] QUARTER = 4'b0100;
    localparam logic [3:0] DOLLAR  = 4'b1000;

    logic        clk;
    logic        rst;
    logic [63:0] price_tbl;
    logic [9:0]  credit_init;
    logic [3:0]  coin_in;
    logic        pay_credit;
    logic [2:0]  sel_idx;
    logic        sel_valid;
    logic        cancel_req;
    logic        vend_ack;
    logic        chg_ready;
    logic        vend_req;
    logic        cancel_ack;
    logic [3:0]  chg_coin;
    logic        chg_valid;
    logic        coin_reject;
    logic [9:0]  balance;
    logic [9:0]  credit_bal;

    int  checks = 0;
    int  errors = 0;
    ev_t sbq[$];
    logic prevVend = 1'b0;
    logic prevCack = 1'b0;

    payment_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .price_tbl   (price_tbl),
        .credit_init (credit_init),
        .coin_in     (coin_in),
        .pay_credit  (pay_credit),
        .sel_idx     (sel_idx),
        .sel_valid   (sel_valid),
        .cancel_req  (cancel_req),
        .vend_ack    (vend_ack),
        .chg_ready   (chg_ready),
        .vend_req    (vend_req),
        .cancel_ack  (cancel_ack),
        .chg_coin    (chg_coin),
        .chg_valid   (chg_valid),
        .coin_reject (coin_reject),
        .balance     (balance),
        .credit_bal  (credit_bal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] vend_data(input logic [9:0] credit, input logic [9:0] bal);
        return {12'd0, credit, bal};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_t kind, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        sbq.push_back(e);
    endtask

    task automatic sb_match(input ev_kind_t kind, input logic [31:0] data);
        ev_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got %s data %0d expected no event", kind.name(), data);
        end else begin
            e = sbq.pop_front();
            if (e.kind != kind || e.data !== data) begin
                errors++;
                $display("FAIL sb_event: got %s data %0d expected %s data %0d",
                         kind.name(), data, e.kind.name(), e.data);
            end
        end
    endtask

    // Monitor: one event per output condition, compared in arrival order.
    always @(negedge clk) begin
        if (!rst) begin
            if (vend_req && !prevVend) sb_match(EV_VEND, vend_data(credit_bal, balance));
            if (chg_valid && chg_ready) sb_match(EV_CHG, 32'(chg_coin));
            if (coin_reject) sb_match(EV_REJ, 32'(balance));
            if (cancel_ack && !prevCack) sb_match(EV_CACK, 32'(balance));
        end
        prevVend <= vend_req;
        prevCack <= cancel_ack;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic insert_coin(input logic [3:0] ch);
        coin_in = ch;
        tick(1);
        coin_in = 4'b0000;
        tick(1);
    endtask

    task automatic buy(input logic [2:0] idx, input logic credit);
        sel_idx    = idx;
        pay_credit = credit;
        sel_valid  = 1'b1;
        tick(1);
        sel_valid  = 1'b0;
    endtask

    task automatic vend_handshake(input string name);
        for (int i = 0; i < 20 && !vend_req; i++) tick(1);
        check({name, "_vend_req"}, 32'(vend_req), 1);
        vend_ack = 1'b1;
        for (int i = 0; i < 20 && vend_req; i++) tick(1);
        check({name, "_vend_drop"}, 32'(vend_req), 0);
        vend_ack = 1'b0;
        tick(1);
    endtask

    task automatic cancel_handshake(input string name);
        cancel_req = 1'b1;
        for (int i = 0; i < 60 && !cancel_ack; i++) tick(1);
        check({name, "_cack_up"}, 32'(cancel_ack), 1);
        tick(2);
        check({name, "_cack_hold"}, 32'(cancel_ack), 1);
        cancel_req = 1'b0;
        tick(1);
        check({name, "_cack_down"}, 32'(cancel_ack), 0);
    endtask

    initial begin
        rst         = 1'b1;
        price_tbl   = {8'd255, 8'd30, 8'd10, 8'd200, 8'd150, 8'd75, 8'd65, 8'd50};
        credit_init = 10'd200;
        coin_in     = 4'b0000;
        pay_credit  = 1'b0;
        sel_idx     = 3'd0;
        sel_valid   = 1'b0;
        cancel_req  = 1'b0;
        vend_ack    = 1'b0;
        chg_ready   = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);

        // Reset state
        check("rst_vend_req", 32'(vend_req), 0);
        check("rst_cancel_ack", 32'(cancel_ack), 0);
        check("rst_chg_valid", 32'(chg_valid), 0);
        check("rst_balance", 32'(balance), 0);
        check("rst_credit", 32'(credit_bal), 200);

        // Cash exact: three quarters buy item 2 (75), no change
        repeat (3) insert_coin(QUARTER);
        check("exact_bal_in", 32'(balance), 75);
        expect_ev(EV_VEND, vend_data(10'd200, 10'd0));
        buy(3'd2, 1'b0);
        vend_handshake("exact");
        tick(3);
        check("exact_bal_out", 32'(balance), 0);

        // Overpay: dollar buys item 1 (65), change quarter then dime
        insert_coin(DOLLAR);
        check("over_bal_in", 32'(balance), 100);
        expect_ev(EV_VEND, vend_data(10'd200, 10'd35));
        expect_ev(EV_CHG, 32'(QUARTER));
        expect_ev(EV_CHG, 32'(DIME));
        buy(3'd1, 1'b0);
        vend_handshake("over");
        tick(5);
        check("over_bal_out", 32'(balance), 0);

        // Cancel: 40 inserted, returned as quarter, dime, nickel
        insert_coin(DIME);
        insert_coin(NICKEL);
        insert_coin(QUARTER);
        check("cancel_bal_in", 32'(balance), 40);
        expect_ev(EV_CHG, 32'(QUARTER));
        expect_ev(EV_CHG, 32'(DIME));
        expect_ev(EV_CHG, 32'(NICKEL));
        expect_ev(EV_CACK, 32'd0);
        cancel_handshake("cancel");
        check("cancel_bal_out", 32'(balance), 0);

        // Credit: 200 - 150 = 50, second 150 purchase refused
        expect_ev(EV_VEND, vend_data(10'd50, 10'd0));
        buy(3'd3, 1'b1);
        vend_handshake("credit1");
        tick(2);
        check("credit1_bal", 32'(credit_bal), 50);
        sel_idx    = 3'd3;
        pay_credit = 1'b1;
        sel_valid  = 1'b1;
        tick(3);
        check("credit2_no_vend", 32'(vend_req), 0);
        check("credit2_bal", 32'(credit_bal), 50);
        sel_valid  = 1'b0;
        pay_credit = 1'b0;

        // Coin during VEND rejected; cancel held off until purchase ends
        insert_coin(DIME);
        expect_ev(EV_VEND, vend_data(10'd50, 10'd0));
        expect_ev(EV_REJ, 32'd0);
        expect_ev(EV_CACK, 32'd0);
        buy(3'd5, 1'b0);
        insert_coin(NICKEL);
        check("vendrej_bal", 32'(balance), 0);
        cancel_req = 1'b1;
        tick(2);
        check("vendrej_hold_vend", 32'(vend_req), 1);
        check("vendrej_hold_cack", 32'(cancel_ack), 0);
        vend_handshake("vendrej");
        cancel_handshake("vendrej");

        // Saturation: 1000 + 25 clamps to 1023 and rejects; more coins reject
        repeat (10) insert_coin(DOLLAR);
        check("sat_bal_1000", 32'(balance), 1000);
        expect_ev(EV_REJ, 32'd1023);
        insert_coin(QUARTER);
        check("sat_bal_clamp", 32'(balance), 1023);
        expect_ev(EV_REJ, 32'd1023);
        insert_coin(NICKEL);
        check("sat_bal_hold", 32'(balance), 1023);

        // Cancel from 1023: ten dollars, two dimes, residual 3 kept
        chg_ready  = 1'b0;
        cancel_req = 1'b1;
        tick(3);
        check("sat_stall_valid", 32'(chg_valid), 0);
        check("sat_stall_bal", 32'(balance), 1023);
        for (int i = 0; i < 10; i++) expect_ev(EV_CHG, 32'(DOLLAR));
        expect_ev(EV_CHG, 32'(DIME));
        expect_ev(EV_CHG, 32'(DIME));
        expect_ev(EV_CACK, 32'd3);
        chg_ready = 1'b1;
        cancel_handshake("sat");
        check("sat_residual", 32'(balance), 3);

        // Reset mid-CHANGE with the dispenser stalled
        insert_coin(DOLLAR);
        check("rstchg_bal_in", 32'(balance), 103);
        chg_ready  = 1'b0;
        cancel_req = 1'b1;
        tick(3);
        check("rstchg_stall_valid", 32'(chg_valid), 0);
        rst        = 1'b1;
        cancel_req = 1'b0;
        tick(1);
        check("rstchg_vend_req", 32'(vend_req), 0);
        check("rstchg_cancel_ack", 32'(cancel_ack), 0);
        check("rstchg_chg_valid", 32'(chg_valid), 0);
        check("rstchg_chg_coin", 32'(chg_coin), 0);
        check("rstchg_coin_reject", 32'(coin_reject), 0);
        check("rstchg_balance", 32'(balance), 0);
        check("rstchg_credit", 32'(credit_bal), 200);
        rst       = 1'b0;
        chg_ready = 1'b1;
        tick(4);
        check("rstchg_idle_valid", 32'(chg_valid), 0);

        tick(2);
        check("sb_drain", 32'(sbq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
